// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction-memory address, and predicts
// the next PC with a direct-mapped BTB of 2-bit counters trained from EX resolution.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_en,
    input  logic        ex_redirect_valid,
    input  logic [31:0] ex_redirect_pc,
    input  logic        ex_update_valid,
    input  logic [31:0] ex_update_pc,
    input  logic        ex_update_taken,
    input  logic [31:0] ex_update_target,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    output logic        if_flush
);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t btb [BTB_ENTRIES];
    logic       started;

    logic [IDX_W-1:0] look_idx, upd_idx;
    logic [TAG_W-1:0] look_tag, upd_tag;
    logic             look_hit, upd_hit;

    // Low address bits are architecturally zero; they feed nothing.
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, ex_update_pc[1:0], ex_redirect_pc[1:0]};

    assign look_idx = if_pc[IDX_W+1:2];
    assign look_tag = if_pc[31:IDX_W+2];
    assign look_hit = btb[look_idx].valid && (btb[look_idx].tag == look_tag);

    assign upd_idx  = ex_update_pc[IDX_W+1:2];
    assign upd_tag  = ex_update_pc[31:IDX_W+2];
    assign upd_hit  = btb[upd_idx].valid && (btb[upd_idx].tag == upd_tag);

    assign if_pred_taken  = look_hit && btb[look_idx].ctr[1];
    assign if_pred_target = look_hit ? btb[look_idx].target : 32'h0;

    assign imem_addr = if_pc;
    assign imem_en   = rst | pipeline_en | ex_redirect_valid;
    assign if_flush  = ex_redirect_valid | ~started;

    // A redirect wins even while stalled so the wrong path is abandoned immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc   <= {RESET_PC[31:2], 2'b00};
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (ex_redirect_valid)
                if_pc <= {ex_redirect_pc[31:2], 2'b00};
            else if (!pipeline_en)
                if_pc <= if_pc;
            else if (if_pred_taken)
                if_pc <= {if_pred_target[31:2], 2'b00};
            else
                if_pc <= if_pc + 32'd4;
        end
    end

    // Training reads pre-update contents, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid  <= 1'b0;
                btb[i].tag    <= '0;
                btb[i].target <= '0;
                btb[i].ctr    <= 2'b01;
            end
        end else if (ex_update_valid) begin
            if (ex_update_taken) begin
                btb[upd_idx].target <= ex_update_target;
                if (upd_hit) begin
                    if (btb[upd_idx].ctr != 2'b11)
                        btb[upd_idx].ctr <= btb[upd_idx].ctr + 2'b01;
                end else begin
                    btb[upd_idx].valid <= 1'b1;
                    btb[upd_idx].tag   <= upd_tag;
                    btb[upd_idx].ctr   <= 2'b10;
                end
            end else if (upd_hit && btb[upd_idx].ctr != 2'b00) begin
                btb[upd_idx].ctr <= btb[upd_idx].ctr - 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench: each driven cycle queues its hand-computed outputs; a negedge monitor
// pops and compares, so stimulus and checking stay decoupled.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipeline_en, ex_redirect_valid, ex_update_valid, ex_update_taken;
    logic [31:0] ex_redirect_pc, ex_update_pc, ex_update_target;
    logic [31:0] imem_addr, if_pc, if_pred_target;
    logic        imem_en, if_pred_taken, if_flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic        fl;
        logic        en;
    } exp_t;

    exp_t q[$];

    if_fetch_unit #(.RESET_PC(32'h0), .BTB_ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .pipeline_en(pipeline_en),
        .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
        .ex_update_valid(ex_update_valid), .ex_update_pc(ex_update_pc),
        .ex_update_taken(ex_update_taken), .ex_update_target(ex_update_target),
        .imem_addr(imem_addr), .imem_en(imem_en), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target), .if_flush(if_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("if_pc",          if_pc,                  e.pc);
            chk("imem_addr",      imem_addr,              e.pc);
            chk("if_pred_taken",  {31'h0, if_pred_taken}, {31'h0, e.pt});
            chk("if_pred_target", if_pred_target,         e.tgt);
            chk("if_flush",       {31'h0, if_flush},      {31'h0, e.fl});
            chk("imem_en",        {31'h0, imem_en},       {31'h0, e.en});
        end
    end

    // Drive one cycle's inputs at posedge+1 and queue the outputs expected during that cycle.
    task automatic cyc(input logic en, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic [31:0] epc, input logic ept,
                       input logic [31:0] etg, input logic efl);
        exp_t e;
        pipeline_en       = en;
        ex_redirect_valid = rv;
        ex_redirect_pc    = rpc;
        ex_update_valid   = uv;
        ex_update_pc      = upc;
        ex_update_taken   = ut;
        ex_update_target  = utg;
        e = '{epc, ept, etg, efl, (rst | en | rv)};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nx(input logic [31:0] epc, input logic ept, input logic [31:0] etg);
        cyc(1, 0, 0, 0, 0, 0, 0, epc, ept, etg, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pipeline_en = 0; ex_redirect_valid = 0; ex_redirect_pc = 0;
        ex_update_valid = 0; ex_update_pc = 0; ex_update_taken = 0; ex_update_target = 0;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1);          // in reset: flush=1, imem_en=1
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1);          // first fetch squashed
        nx(32'h4, 0, 0);
        nx(32'h8, 0, 0);
        nx(32'hC, 0, 0);
        // stall three cycles at 0x10
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0);
        nx(32'h10, 0, 0);
        // redirect while stalled; low redirect bits ignored
        cyc(0, 1, 32'h203, 0, 0, 0, 0, 32'h14, 0, 0, 1);
        // train 0x40 -> 0x100 (low update bits ignored), then visit 0x40
        cyc(1, 0, 0, 1, 32'h42, 1, 32'h100, 32'h200, 0, 0, 0);
        cyc(1, 1, 32'h40, 0, 0, 0, 0, 32'h204, 0, 0, 1);
        nx(32'h40, 1, 32'h100);
        // two not-taken: 10 -> 01 -> 00
        cyc(1, 0, 0, 1, 32'h40, 0, 0, 32'h100, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h40, 0, 0, 32'h104, 0, 0, 0);
        cyc(1, 1, 32'h40, 0, 0, 0, 0, 32'h108, 0, 0, 1);
        nx(32'h40, 0, 32'h100);                              // hit, strongly not-taken
        // taken x5: 00->01->10->11->11->11, then one not-taken -> 10
        cyc(1, 0, 0, 1, 32'h40, 1, 32'h100, 32'h44, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h40, 1, 32'h100, 32'h48, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h40, 1, 32'h100, 32'h4C, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h40, 1, 32'h100, 32'h50, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h40, 1, 32'h100, 32'h54, 0, 0, 0);
        cyc(1, 1, 32'h40, 1, 32'h40, 0, 0, 32'h58, 0, 0, 1);
        nx(32'h40, 1, 32'h100);
        // alias 0x80 shares index 0 with 0x40
        cyc(1, 1, 32'h80, 0, 0, 0, 0, 32'h100, 0, 0, 1);
        cyc(1, 0, 0, 1, 32'h80, 1, 32'h300, 32'h80, 0, 0, 0);
        cyc(1, 1, 32'h40, 0, 0, 0, 0, 32'h84, 0, 0, 1);
        cyc(1, 1, 32'h80, 0, 0, 0, 0, 32'h40, 0, 0, 1);     // 0x40 evicted
        nx(32'h80, 1, 32'h300);
        // simultaneous lookup/update with counter 01
        cyc(1, 0, 0, 1, 32'h40, 1, 32'h100, 32'h300, 0, 0, 0);
        cyc(1, 1, 32'h40, 1, 32'h40, 0, 0, 32'h304, 0, 0, 1);
        cyc(1, 1, 32'h40, 1, 32'h40, 1, 32'h100, 32'h40, 0, 32'h100, 1);
        cyc(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h40, 1, 32'h100, 1);
        // PC wrap
        nx(32'hFFFF_FFFC, 0, 0);
        nx(32'h0, 0, 0);
        // reset mid-operation with an update in flight
        rst = 1'b1;
        cyc(1, 0, 0, 1, 32'h40, 1, 32'h200, 32'h0, 0, 0, 1);
        rst = 1'b0;
        cyc(1, 1, 32'h40, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        nx(32'h40, 0, 0);                                    // BTB cleared
        nx(32'h44, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-stage producer for the IF/ID pipeline register.
- Owns the PC register and drives the synchronous instruction-memory address. Generates if_pc, if_pred_taken and if_flush.
- Contains a direct-mapped BTB with 2-bit saturating counters for next-PC prediction. The BTB is trained by EX-stage branch resolution.
- Instruction memory is registered, so instruction data for if_pc appears one clock after if_pc is presented, aligned with the IF/ID capture edge.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256.
- IDX_W, 4, log2(BTB_ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pipeline_en  in  1  1 = front end advances; 0 = stall, hold PC
- ex_redirect_valid  in  1  EX misprediction or jump; restart fetch at ex_redirect_pc
- ex_redirect_pc  in  32  corrected fetch address
- ex_update_valid  in  1  resolved control-flow instruction in EX; train BTB
- ex_update_pc  in  32  PC of resolved branch
- ex_update_taken  in  1  actual branch outcome
- ex_update_target  in  32  actual taken target
- imem_addr  out  32  instruction memory address; equals if_pc
- imem_en  out  1  instruction memory read enable
- if_pc  out  32  PC of instruction being fetched
- if_pred_taken  out  1  BTB predicts taken for if_pc
- if_pred_target  out  32  predicted target; valid when if_pred_taken=1
- if_flush  out  1  instruction at if_pc must be squashed downstream

Behaviour:
- Reset (async):
  - if_pc = RESET_PC.
  - All BTB valid bits = 0; all counters = 2'b01 (weakly not-taken).
  - started = 0.
  - Outputs during reset: if_pred_taken = 0; if_flush = 1; imem_en = 1.
- Combinational outputs:
  - imem_addr = if_pc.
  - imem_en = pipeline_en | ex_redirect_valid.
- Lookup, combinational on if_pc:
  - hit = valid[idx] & (tag[idx] == if_pc tag field).
  - if_pred_taken = hit & counter[idx][1].
  - if_pred_target = target[idx]; 0 when there is no hit.
- Next-PC priority, evaluated at each posedge:
  1. ex_redirect_valid: pc <= ex_redirect_pc. Applies even when pipeline_en = 0.
  2. else if !pipeline_en: pc holds.
  3. else if if_pred_taken: pc <= if_pred_target.
  4. else: pc <= if_pc + 4. Wraps modulo 2^32 (32'hFFFFFFFC -> 0).
- if_flush = ex_redirect_valid | ~started.
  - started is set to 1 at the first posedge after reset deassertion, then stays 1.
  - Effect: the first fetch after reset and the wrong-path fetch in a redirect cycle are both marked squashed.
- BTB update, at posedge when ex_update_valid (independent of pipeline_en and redirect):
  - Taken, miss: allocate valid = 1, write tag and target, counter = 2'b10. Any previous entry at that index is overwritten.
  - Taken, hit: write target; counter saturating increment (max 2'b11).
  - Not taken, hit: counter saturating decrement (min 2'b00); valid stays 1.
  - Not taken, miss: no change.
- Same-cycle lookup and update to the same index: the lookup uses pre-update contents; the new contents are visible from the next cycle.
- Latency:
  - Redirect to new if_pc: 1 cycle.
  - BTB training to prediction effect: 1 cycle.
- Reset mid-operation: all state returns to reset values immediately; any in-flight update is discarded.
- ex_update_pc[1:0] and ex_redirect_pc[1:0] are ignored (treated as 0). if_pc[1:0] is always 0.

Test Plan:
- Reset release with RESET_PC = 0, pipeline_en = 1 -> cycle 0: if_pc = 0, if_flush = 1. Then if_pc = 4, 8, 12 with if_flush = 0 and if_pred_taken = 0.
- Stall: pipeline_en = 0 for 3 cycles at if_pc = 0x10 -> if_pc stays 0x10. Resumes at 0x14 when pipeline_en returns to 1.
- Redirect while stalled: pipeline_en = 0, ex_redirect_valid = 1, ex_redirect_pc = 0x200 -> if_flush = 1 that cycle; next cycle if_pc = 0x200.
- Train BTB: update pc = 0x40, taken, target 0x100 -> on next visit to 0x40, if_pred_taken = 1, if_pred_target = 0x100, following if_pc = 0x100.
  - Two not-taken updates -> counter 2'b00, if_pred_taken = 0, fetch 0x44.
  - Counter saturation: three taken updates stop at 2'b11.
- Alias: entry for 0x40 present, fetch 0x80 (same index with IDX_W = 4, different tag) -> no hit, pc + 4.
  - Taken update at 0x80 replaces the entry; 0x40 now misses.
- Simultaneous: lookup at 0x40 in the same cycle a taken update for 0x40 arrives (counter previously 2'b01) -> if_pred_taken = 0 that cycle, 1 on the next lookup of 0x40.
- Wrap: redirect to 0xFFFFFFFC with no BTB hit -> next if_pc = 0x00000000.
